keypad_matrix_scanner: RTL and testbench

//  Drives the columns of a 4x3 matrix keypad, senses its rows and produces the debounced
//  one-hot 12-bit key code consumed by keypad_scan on Keypad_in. One key is reported per press.

---
 rtl/keypad_pkg.sv | 50 +++++
 rtl/keypad_tick_gen.sv | 27 ++
 rtl/keypad_matrix_scanner.sv | 184 ++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key-code mapping for the 4x3 keypad scanner.
// Key code is one-hot: digits 1..9 -> bits 0..8, 0 -> bit 9, * -> bit 10, # -> bit 11.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = 12;

  localparam int KEY_1    = 0;
  localparam int KEY_2    = 1;
  localparam int KEY_3    = 2;
  localparam int KEY_4    = 3;
  localparam int KEY_5    = 4;
  localparam int KEY_6    = 5;
  localparam int KEY_7    = 6;
  localparam int KEY_8    = 7;
  localparam int KEY_9    = 8;
  localparam int KEY_0    = 9;
  localparam int KEY_STAR = 10;
  localparam int KEY_HASH = 11;

  function automatic logic [NUM_KEYS-1:0] map_key(input logic [1:0] row, input logic [1:0] col);
    logic [NUM_KEYS-1:0] code;
    code = '0;
    case ({row, col})
      4'b00_00: code[KEY_1]    = 1'b1;
      4'b00_01: code[KEY_2]    = 1'b1;
      4'b00_10: code[KEY_3]    = 1'b1;
      4'b01_00: code[KEY_4]    = 1'b1;
      4'b01_01: code[KEY_5]    = 1'b1;
      4'b01_10: code[KEY_6]    = 1'b1;
      4'b10_00: code[KEY_7]    = 1'b1;
      4'b10_01: code[KEY_8]    = 1'b1;
      4'b10_10: code[KEY_9]    = 1'b1;
      4'b11_00: code[KEY_STAR] = 1'b1;
      4'b11_01: code[KEY_0]    = 1'b1;
      4'b11_10: code[KEY_HASH] = 1'b1;
      default:  code           = '0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Prescaler producing a one-clk tick every CLK_DIV clocks (count 0..CLK_DIV-1, tick at CLK_DIV-1).
// Latency: first tick CLK_DIV-1 clocks after reset; free-running, no backpressure.
module keypad_tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x3 keypad column scanner with row debounce; emits one registered one-hot key code per press.
// Latency: DEBOUNCE_TICKS ticks from the detecting tick plus 2 clk sync; no backpressure (pulse output).
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [2:0]  col_out,
  output logic [11:0] key_onehot,
  output logic        key_valid,
  output logic        key_held
);

  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS);

  logic              tick;
  logic [3:0]        row_meta;
  logic [3:0]        row_sync;

  scan_state_t       state,      state_n;
  logic [2:0]        col_n;
  logic [1:0]        lat_row,    lat_row_n;
  logic [1:0]        lat_col,    lat_col_n;
  logic [CNT_W-1:0]  cnt,        cnt_n;
  logic [11:0]       key_onehot_n;
  logic              key_valid_n;
  logic              key_held_n;

  logic [1:0]        lowest_row;
  logic [1:0]        col_idx;
  logic [2:0]        col_rot;
  logic [CNT_W-1:0]  cnt_inc;
  logic              row_hit;

  keypad_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // Lowest-index high row wins when several rows of the driven column are active.
  always_comb begin
    lowest_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_sync[r]) begin
        lowest_row = 2'(r);
      end
    end
  end

  always_comb begin
    case (col_out)
      3'b010:  col_idx = 2'd1;
      3'b100:  col_idx = 2'd2;
      default: col_idx = 2'd0;
    endcase
  end

  assign col_rot = {col_out[1:0], col_out[2]};
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign row_hit = row_sync[lat_row];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN;
      col_out    <= 3'b001;
      lat_row    <= 2'd0;
      lat_col    <= 2'd0;
      cnt        <= '0;
      key_onehot <= '0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      state      <= state_n;
      col_out    <= col_n;
      lat_row    <= lat_row_n;
      lat_col    <= lat_col_n;
      cnt        <= cnt_n;
      key_onehot <= key_onehot_n;
      key_valid  <= key_valid_n;
      key_held   <= key_held_n;
    end
  end

  always_comb begin
    state_n      = state;
    col_n        = col_out;
    lat_row_n    = lat_row;
    lat_col_n    = lat_col;
    cnt_n        = cnt;
    key_onehot_n = key_onehot;
    key_valid_n  = 1'b0;
    key_held_n   = key_held;

    if (tick) begin
      case (state)
        SCAN: begin
          if (|row_sync) begin
            lat_row_n = lowest_row;
            lat_col_n = col_idx;
            cnt_n     = CNT_W'(1);
            if (DEBOUNCE_TICKS == 1) begin
              state_n      = PRESSED;
              key_onehot_n = map_key(lowest_row, col_idx);
              key_valid_n  = 1'b1;
              key_held_n   = 1'b1;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            col_n = col_rot;
          end
        end

        DEBOUNCE: begin
          if (row_hit) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_n      = PRESSED;
              key_onehot_n = map_key(lat_row, lat_col);
              key_valid_n  = 1'b1;
              key_held_n   = 1'b1;
            end
          end else begin
            state_n = SCAN;
            col_n   = col_rot;
          end
        end

        PRESSED: begin
          // Only the latched row matters here; other keys cannot steal a held press.
          if (!row_hit) begin
            if (DEBOUNCE_TICKS == 1) begin
              state_n      = SCAN;
              key_onehot_n = '0;
              key_held_n   = 1'b0;
              col_n        = col_rot;
            end else begin
              state_n = RELEASE;
              cnt_n   = CNT_W'(1);
            end
          end
        end

        RELEASE: begin
          if (!row_hit) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_n      = SCAN;
              key_onehot_n = '0;
              key_held_n   = 1'b0;
              col_n        = col_rot;
            end
          end else begin
            // Bounce back to the held state without re-announcing the key.
            state_n = PRESSED;
          end
        end

        default: begin
          state_n = SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Randomized bench for keypad_matrix_scanner: a keypad model drives rows from col_out and pressed keys.
module tb_keypad_matrix_scanner;

  localparam int CLK_DIV = 4;
  localparam int DT      = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [2:0]  col_out;
  logic [11:0] key_onehot;
  logic        key_valid;
  logic        key_held;

  logic [11:0] pressed = '0;   // key index = row*3 + col
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  logic [11:0] valid_code = '0;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .CLK_DIV        (CLK_DIV),
    .DEBOUNCE_TICKS (DT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_onehot (key_onehot),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  // Physical keypad: a pressed key connects its column drive to its row.
  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3 + c] && col_out[c]) row_in[r] = 1'b1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      valid_cnt  = valid_cnt + 1;
      valid_cyc  = cyc;
      valid_code = key_onehot;
    end
  end

  function automatic logic [11:0] code_of(input int k);
    string lbl;
    byte   ch;
    logic [11:0] c;
    lbl = "123456789*0#";
    ch  = lbl[k];
    c   = '0;
    if (ch == "0") c[9] = 1'b1;
    else if (ch == "*") c[10] = 1'b1;
    else if (ch == "#") c[11] = 1'b1;
    else c[int'(ch) - int'("1")] = 1'b1;
    return c;
  endfunction

  function automatic logic [2:0] col_bits(input int c);
    return 3'(1 << (c % 3));
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_col_enter(input logic [2:0] target, output bit ok);
    logic [2:0] prev;
    ok = 1'b0;
    for (int i = 0; i < 4*CLK_DIV + 2; i++) begin
      prev = col_out;
      step();
      if (col_out == target && prev != target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (valid_cnt > base) begin ok = 1'b1; break; end
      step();
    end
    if (valid_cnt > base) ok = 1'b1;
  endtask

  task automatic wait_release(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (key_held == 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  // Press a key set, expect a single report of exp from column exp_col, hold, then release.
  task automatic run_press(input logic [11:0] mask, input logic [11:0] exp, input int exp_col,
                           input int hold, input string name);
    int base, t0, t1;
    bit ok;
    base = valid_cnt;
    pressed = mask;
    t0 = cyc;
    wait_valid(base, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_valid_timeout: valid count %0d, required %0d", name, valid_cnt, base + 1);
    end else begin
      checks++;
      if (valid_code !== exp) begin
        errors++;
        $display("FAIL %s_code: got %h, required %h", name, valid_code, exp);
      end
      checks++;
      if (valid_cyc - t0 < (DT-1)*CLK_DIV + 2 || valid_cyc - t0 > (DT+2)*CLK_DIV + 6) begin
        errors++;
        $display("FAIL %s_latency: got %0d clk, required %0d..%0d", name, valid_cyc - t0,
                 (DT-1)*CLK_DIV + 2, (DT+2)*CLK_DIV + 6);
      end
    end
    repeat (hold) step();
    checks++;
    if (key_held !== 1'b1 || key_onehot !== exp || valid_cnt != base + 1) begin
      errors++;
      $display("FAIL %s_hold: held %b code %h valids %0d, required 1 %h %0d", name, key_held,
               key_onehot, valid_cnt - base, exp, 1);
    end
    pressed = '0;
    t1 = cyc;
    wait_release(40, ok);
    checks++;
    if (!ok || cyc - t1 < (DT-1)*CLK_DIV + 2 || cyc - t1 > DT*CLK_DIV + 3) begin
      errors++;
      $display("FAIL %s_release: ok %0d after %0d clk, required %0d..%0d", name, ok, cyc - t1,
               (DT-1)*CLK_DIV + 2, DT*CLK_DIV + 3);
    end
    checks++;
    if (key_onehot !== 12'h000 || col_out !== col_bits(exp_col + 1)) begin
      errors++;
      $display("FAIL %s_after_release: code %h col %b, required 000 %b", name, key_onehot, col_out,
               col_bits(exp_col + 1));
    end
  endtask

  task automatic test_reset();
    logic [2:0] prev;
    int last, changes;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (col_out !== 3'b001 || key_onehot !== 12'h000 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: col %b code %h valid %b held %b, required 001 000 0 0",
               col_out, key_onehot, key_valid, key_held);
    end
    rst = 1'b0;
    last = cyc;
    changes = 0;
    for (int i = 0; i < 12*CLK_DIV; i++) begin
      prev = col_out;
      step();
      checks++;
      if (key_valid !== 1'b0 || key_onehot !== 12'h000 || key_held !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet: valid %b code %h held %b, required 0 000 0", key_valid, key_onehot, key_held);
      end
      if (col_out !== prev) begin
        checks++;
        if (col_out !== {prev[1:0], prev[2]} || cyc - last != CLK_DIV) begin
          errors++;
          $display("FAIL idle_rotate: %b -> %b after %0d clk, required %b after %0d", prev, col_out,
                   cyc - last, {prev[1:0], prev[2]}, CLK_DIV);
        end
        last = cyc;
        changes++;
      end
    end
    checks++;
    if (changes != 12) begin
      errors++;
      $display("FAIL idle_change_count: got %0d, required %0d", changes, 12);
    end
  endtask

  task automatic test_single_keys();
    run_press(12'(1 << 4), 12'h010, 1, 10, "key5");
    run_press(12'(1 << 11), 12'h800, 2, 6, "keyhash");
    run_press(12'(1 << 10), 12'h200, 1, 6, "key0");
    run_press(12'(1 << 9), 12'h400, 0, 6, "keystar");
  endtask

  task automatic test_bounce();
    int base, t0, k;
    bit ok;
    base = valid_cnt;
    wait_col_enter(3'b001, ok);
    k = $urandom_range(1, DT-1);
    pressed[6] = 1'b1;
    repeat (k*CLK_DIV) step();
    pressed = '0;
    repeat (2*CLK_DIV) step();
    checks++;
    if (!ok || valid_cnt != base || key_held !== 1'b0) begin
      errors++;
      $display("FAIL bounce_press: ok %0d valids %0d held %b, required 1 0 0", ok, valid_cnt - base, key_held);
    end
    wait_col_enter(3'b001, ok);
    pressed[6] = 1'b1;
    t0 = cyc;
    wait_valid(base, 40, ok);
    checks++;
    if (!ok || valid_code !== 12'h040 || valid_cyc - t0 != DT*CLK_DIV) begin
      errors++;
      $display("FAIL bounce_confirm: ok %0d code %h latency %0d, required 1 040 %0d", ok, valid_code,
               valid_cyc - t0, DT*CLK_DIV);
    end
    k = $urandom_range(1, DT-1);
    pressed = '0;
    repeat (k*CLK_DIV) step();
    pressed[6] = 1'b1;
    repeat (4*CLK_DIV) step();
    checks++;
    if (key_held !== 1'b1 || key_onehot !== 12'h040 || valid_cnt != base + 1) begin
      errors++;
      $display("FAIL bounce_release: held %b code %h valids %0d, required 1 040 1", key_held, key_onehot,
               valid_cnt - base);
    end
    pressed = '0;
    wait_release(40, ok);
    checks++;
    if (!ok || key_onehot !== 12'h000 || col_out !== 3'b010 || valid_cnt != base + 1) begin
      errors++;
      $display("FAIL bounce_final: ok %0d code %h col %b valids %0d, required 1 000 010 1", ok, key_onehot,
               col_out, valid_cnt - base);
    end
  endtask

  task automatic test_multi_key();
    bit ok;
    int base, cur, win, n;
    logic [11:0] mask;
    wait_col_enter(3'b001, ok);
    run_press(12'h101, 12'h001, 0, 8, "multi19");
    base = valid_cnt;
    repeat (20*CLK_DIV) step();
    checks++;
    if (valid_cnt != base || key_onehot !== 12'h000) begin
      errors++;
      $display("FAIL multi_after: valids %0d code %h, required 0 000", valid_cnt - base, key_onehot);
    end
    for (int it = 0; it < 6; it++) begin
      cur = $urandom_range(0, 2);
      wait_col_enter(col_bits(cur), ok);
      mask = '0;
      n = $urandom_range(2, 3);
      while ($countones(mask) < n) mask[$urandom_range(0, 11)] = 1'b1;
      // Scan order starts at the column being driven right now, then lowest row.
      win = -1;
      for (int off = 0; off < 3 && win < 0; off++)
        for (int r = 0; r < 4 && win < 0; r++)
          if (mask[r*3 + (cur + off) % 3]) win = r*3 + (cur + off) % 3;
      run_press(mask, code_of(win), win % 3, $urandom_range(0, 12), "multirand");
    end
  endtask

  task automatic test_random_keys();
    int k;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 11);
      repeat ($urandom_range(0, 15)) step();
      run_press(12'(1 << k), code_of(k), k % 3, $urandom_range(0, 20), "rand");
    end
  endtask

  task automatic test_reset_pressed();
    bit ok;
    int base;
    base = valid_cnt;
    pressed[5] = 1'b1;
    wait_valid(base, 60, ok);
    repeat (2) step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (!ok || col_out !== 3'b001 || key_onehot !== 12'h000 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ok %0d col %b code %h valid %b held %b, required 1 001 000 0 0", ok,
               col_out, key_onehot, key_valid, key_held);
    end
    step();
    rst = 1'b0;
    base = valid_cnt;
    wait_valid(base, 60, ok);
    checks++;
    if (!ok || valid_code !== 12'h020) begin
      errors++;
      $display("FAIL reset_redetect: ok %0d code %h, required 1 020", ok, valid_code);
    end
    repeat (3*CLK_DIV) step();
    pressed = '0;
    wait_release(40, ok);
    checks++;
    if (!ok || valid_cnt != base + 1 || key_onehot !== 12'h000) begin
      errors++;
      $display("FAIL reset_release: ok %0d valids %0d code %h, required 1 1 000", ok, valid_cnt - base, key_onehot);
    end
  endtask

  initial begin
    test_reset();
    test_single_keys();
    test_bounce();
    test_multi_key();
    test_random_keys();
    test_reset_pressed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
